// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 receive path: bit-index encoding,
// frame length and default timing parameters.
package ps2_pkg;

    typedef logic [3:0] ps2_idx_t;

    localparam ps2_idx_t PS2_IDLE   = 4'd0;
    localparam ps2_idx_t PS2_PARITY = 4'd9;
    localparam ps2_idx_t PS2_STOP   = 4'd10;

    localparam int PS2_FRAME_LEN        = 11;
    localparam int PS2_FILTER_LEN_DEF   = 8;
    localparam int PS2_TIMEOUT_CYC_DEF  = 200000;

    // Odd parity holds when the data bits plus the parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_glitch_filter.sv
// Two-flop synchronizer followed by a persistence filter: the output level
// only follows the line once it has held a new value for FILTER_LEN samples.
module ps2_glitch_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o
);

    logic       meta_q;
    logic       sync_q;
    logic       level_q;
    logic [7:0] cnt_q;

    // Bring the asynchronous line into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
        end
    end

    // Count samples that disagree with the filtered level; flip on the FILTER_LEN-th one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b1;
            cnt_q   <= 8'd0;
        end else if (sync_q == level_q) begin
            cnt_q   <= 8'd0;
        end else if (cnt_q == 8'(FILTER_LEN - 1)) begin
            level_q <= sync_q;
            cnt_q   <= 8'd0;
        end else begin
            cnt_q   <= cnt_q + 8'd1;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 device-to-host receiver for the mouse path. Frames 11-bit characters
// (start, 8 data LSB first, odd parity, stop) on filtered clock falling edges.
// Optional build macro: PS2_PARITY_CHECK_EN drops bytes with bad parity and
// pulses parityErr; without it parity is ignored and parityErr is tied low.
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = PS2_FILTER_LEN_DEF,
    parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic       mouseReady,
    output logic [7:0] mouseData,
    output logic [3:0] mouseState,
    output logic       parityErr,
    output logic       frameErr
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic            clk_filt;
    logic            clk_filt_prev_q;
    logic            fall;
    logic            data_meta_q;
    logic            data_sync_q;
    ps2_idx_t        state_q;
    logic [8:0]      shift_q;
    logic [WD_W-1:0] wd_q;
    logic            wd_expired;
    logic            ready_q;
    logic [7:0]      data_q;
    logic            frame_err_q;

    ps2_glitch_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2Clk),
        .level_o (clk_filt)
    );

    // Data line needs only synchronization; it is sampled well after it settles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= ps2Data;
            data_sync_q <= data_meta_q;
        end
    end

    // Delay the filtered clock one cycle for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) clk_filt_prev_q <= 1'b1;
        else      clk_filt_prev_q <= clk_filt;
    end

    assign fall       = clk_filt_prev_q & ~clk_filt;
    assign wd_expired = (state_q != PS2_IDLE) && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog: counts idle time between edges while a frame is in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            wd_q <= '0;
        else if (fall || state_q == PS2_IDLE) wd_q <= '0;
        else if (wd_expired)                 wd_q <= '0;
        else                                 wd_q <= wd_q + 1'b1;
    end

`ifdef PS2_PARITY_CHECK_EN
    logic parity_err_q;
`endif

    // Bit-index state machine with registered strobes and data output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= PS2_IDLE;
            shift_q      <= '0;
            ready_q      <= 1'b0;
            data_q       <= 8'h00;
            frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            ready_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
            // A fall in the expiry cycle still advances the frame.
            if (fall) begin
                if (state_q == PS2_IDLE) begin
                    if (!data_sync_q) begin
                        state_q <= 4'd1;
                        shift_q <= '0;
                    end
                end else if (state_q == PS2_STOP) begin
                    state_q <= PS2_IDLE;
                    if (!data_sync_q) begin
                        frame_err_q <= 1'b1;
                    end
`ifdef PS2_PARITY_CHECK_EN
                    else if (!odd_parity_ok(shift_q[7:0], shift_q[8])) begin
                        parity_err_q <= 1'b1;
                    end
`endif
                    else begin
                        data_q  <= shift_q[7:0];
                        ready_q <= 1'b1;
                    end
                end else begin
                    // Data bits and the parity bit share one right shift; parity lands in bit 8.
                    shift_q <= {data_sync_q, shift_q[8:1]};
                    state_q <= state_q + 4'd1;
                end
            end else if (wd_expired) begin
                state_q     <= PS2_IDLE;
                shift_q     <= '0;
                frame_err_q <= 1'b1;
            end
        end
    end

    assign mouseReady = ready_q;
    assign mouseData  = data_q;
    assign mouseState = state_q;
    assign frameErr   = frame_err_q;
`ifdef PS2_PARITY_CHECK_EN
    assign parityErr  = parity_err_q;
`else
    assign parityErr  = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_mouse_rx.sv
module tb_ps2_mouse_rx;

    localparam int FILT    = 8;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 40;

    localparam int K_READY = 0;
    localparam int K_PERR  = 1;
    localparam int K_FERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       ps2Clk;
    logic       ps2Data;
    logic       mouseReady;
    logic [7:0] mouseData;
    logic [3:0] mouseState;
    logic       parityErr;
    logic       frameErr;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    logic prev_ready;

    ps2_mouse_rx #(
        .FILTER_LEN  (FILT),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2Clk     (ps2Clk),
        .ps2Data    (ps2Data),
        .mouseReady (mouseReady),
        .mouseData  (mouseData),
        .mouseState (mouseState),
        .parityErr  (parityErr),
        .frameErr   (frameErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Drive the first nbits bits of a frame; data changes while the clock is high.
    task automatic send_bits(input logic [7:0] d, input logic bad_par, input logic stop,
                             input int nbits);
        logic [10:0] fr;
        fr = {stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2Data = fr[i];
            wait_cyc(HALF);
            ps2Clk = 1'b0;
            wait_cyc(HALF);
            ps2Clk = 1'b1;
        end
        ps2Data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        send_bits(d, bad_par, stop, 11);
        wait_cyc(HALF);
    endtask

    task automatic pop_cmp(input int kind, input string name);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected pulse, data 0x%0h, nothing queued", name, mouseData);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL %s: got event kind %0d expected kind %0d", name, kind, e.kind);
            end else if (kind == K_READY && mouseData !== e.data) begin
                errors++;
                $display("FAIL %s: mouseData 0x%0h expected 0x%0h", name, mouseData, e.data);
            end
        end
    endtask

    // Monitor: consumes every output strobe and compares against the queue.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (mouseReady === 1'b1) begin
                pop_cmp(K_READY, "ready");
                checks++;
                if (prev_ready === 1'b1) begin
                    errors++;
                    $display("FAIL ready_pulse: high 2 cycles, got 1 expected 0");
                end
            end
            if (parityErr === 1'b1) pop_cmp(K_PERR, "parityErr");
            if (frameErr === 1'b1)  pop_cmp(K_FERR, "frameErr");
        end
        prev_ready = mouseReady;
    end

    initial begin
        checks     = 0;
        errors     = 0;
        prev_ready = 1'b0;
        rst        = 1'b0;
        ps2Clk     = 1'b1;
        ps2Data    = 1'b1;
        wait_cyc(5);
        chk("rst_ready", {31'd0, mouseReady}, 32'd0);
        chk("rst_data",  {24'd0, mouseData},  32'd0);
        chk("rst_state", {28'd0, mouseState}, 32'd0);
        chk("rst_perr",  {31'd0, parityErr},  32'd0);
        chk("rst_ferr",  {31'd0, frameErr},   32'd0);
        rst = 1'b1;
        wait_cyc(20);

        // Single good byte.
        push(K_READY, 8'h08);
        send_frame(8'h08, 1'b0, 1'b1);
        chk("state_after_08", {28'd0, mouseState}, 32'd0);
        chk("data_08", {24'd0, mouseData}, 32'h08);

        // Back-to-back packet.
        push(K_READY, 8'h09);
        push(K_READY, 8'h05);
        push(K_READY, 8'hFB);
        send_frame(8'h09, 1'b0, 1'b1);
        send_frame(8'h05, 1'b0, 1'b1);
        send_frame(8'hFB, 1'b0, 1'b1);
        chk("data_fb", {24'd0, mouseData}, 32'hFB);

        // Wrong parity.
`ifdef PS2_PARITY_CHECK_EN
        push(K_PERR, 8'h00);
        send_frame(8'h08, 1'b1, 1'b1);
        chk("data_kept_bad_par", {24'd0, mouseData}, 32'hFB);
`else
        push(K_READY, 8'h08);
        send_frame(8'h08, 1'b1, 1'b1);
        chk("data_bad_par_deliv", {24'd0, mouseData}, 32'h08);
`endif
        chk("state_after_par", {28'd0, mouseState}, 32'd0);

        // Short clock glitch while idle.
        ps2Clk = 1'b0;
        wait_cyc(3);
        ps2Clk = 1'b1;
        wait_cyc(50);
        chk("state_glitch", {28'd0, mouseState}, 32'd0);

        // Abandoned frame after 5 edges, then a good frame.
        push(K_FERR, 8'h00);
        send_bits(8'h3C, 1'b0, 1'b1, 5);
        wait_cyc(20);
        chk("state_mid_frame", {28'd0, mouseState}, 32'd5);
        wait_cyc(TIMEOUT + 10);
        chk("state_timeout", {28'd0, mouseState}, 32'd0);
        push(K_READY, 8'h28);
        send_frame(8'h28, 1'b0, 1'b1);
        chk("data_28", {24'd0, mouseData}, 32'h28);

        // Bad stop bit.
        push(K_FERR, 8'h00);
        send_frame(8'h55, 1'b0, 1'b0);
        chk("data_kept_bad_stop", {24'd0, mouseData}, 32'h28);

        // Reset in the middle of a frame.
        send_bits(8'hA7, 1'b0, 1'b1, 6);
        wait_cyc(20);
        chk("state_bit6", {28'd0, mouseState}, 32'd6);
        rst = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, mouseReady}, 32'd0);
        chk("midrst_data",  {24'd0, mouseData},  32'd0);
        chk("midrst_state", {28'd0, mouseState}, 32'd0);
        chk("midrst_perr",  {31'd0, parityErr},  32'd0);
        chk("midrst_ferr",  {31'd0, frameErr},   32'd0);
        wait_cyc(10);
        rst = 1'b1;
        wait_cyc(20);
        push(K_READY, 8'h18);
        send_frame(8'h18, 1'b0, 1'b1);
        chk("data_18", {24'd0, mouseData}, 32'h18);

        wait_cyc(100);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
